// File: rtl/audio_bank_buffer.sv
// N-bank audio sample buffer: byte-wide bank writes from the file reader,
// frame-wide little-endian PCM assembly on each sample tick, underrun flagging.
module audio_bank_buffer #(
  parameter int unsigned NUM_BANKS      = 2,
  parameter int unsigned BANK_ADDR_BITS = 9,
  parameter int unsigned CHANNELS       = 2,
  parameter int unsigned SAMPLE_BYTES   = 2,
  localparam int unsigned F             = CHANNELS * SAMPLE_BYTES,
  localparam int unsigned FW            = F * 8,
  localparam int unsigned BW            = $clog2(NUM_BANKS),
  localparam int unsigned LW            = BW + 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  // write side
  input  logic [BANK_ADDR_BITS-1:0] wr_addr_i,
  input  logic                      wr_en_i,
  input  logic [7:0]                wr_data_i,
  input  logic                      wr_filled_i,
  output logic                      wr_empty_o,
  // read side
  input  logic                      play_en_i,
  input  logic                      sample_tick_i,
  output logic [FW-1:0]             frame_o,
  output logic                      frame_valid_o,
  output logic                      underrun_o,
  output logic [15:0]               underrun_count_o,
  output logic [LW-1:0]             level_o
);

  localparam int unsigned AW    = BW + BANK_ADDR_BITS;
  localparam int unsigned Depth = NUM_BANKS << BANK_ADDR_BITS;
  localparam int unsigned CW    = (F > 1) ? $clog2(F) : 1;

  localparam logic [1:0] StIdle     = 2'd0;
  localparam logic [1:0] StFetch    = 2'd1;
  localparam logic [1:0] StAssemble = 2'd2;

  logic [7:0]                mem [Depth];
  logic [7:0]                rd_data_q;

  logic [1:0]                state_q, state_d;
  logic [BW-1:0]             wr_bank_q, wr_bank_d;
  logic [BW-1:0]             rd_bank_q, rd_bank_d;
  logic [BANK_ADDR_BITS-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [LW-1:0]             level_q, level_d;
  logic [FW-1:0]             asm_q, asm_d;
  logic [FW-1:0]             frame_q, frame_d;
  logic                      frame_valid_q, frame_valid_d;
  logic                      underrun_q, underrun_d;
  logic [15:0]               ucnt_q, ucnt_d;

  logic                      wr_empty;
  logic                      wr_accept;
  logic                      commit;
  logic                      release_bank;
  logic                      rd_en;
  logic [FW-1:0]             shifted;
  logic [AW-1:0]             wr_phys;
  logic [AW-1:0]             rd_phys;

  assign wr_empty  = (level_q < LW'(NUM_BANKS));
  assign wr_accept = wr_en_i & wr_empty;
  assign commit    = wr_filled_i & wr_empty;
  assign wr_phys   = {wr_bank_q, wr_addr_i};
  assign rd_phys   = {rd_bank_q, rd_ptr_q};

  // Shift the freshest RAM byte into the top; after F shifts byte 0 sits lowest.
  // The stale byte shifted in on the first fetch cycle falls out the bottom.
  assign shifted = (asm_q >> 8) | (FW'(rd_data_q) << (FW - 8));

  // rd_ptr only returns to zero in ASSEMBLE when the last frame of a bank was read.
  assign release_bank = (state_q == StAssemble) && (rd_ptr_q == '0);

  // Byte RAM: synchronous write, registered read; contents are not reset.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      mem[wr_phys] <= wr_data_i;
    end
    if (rd_en) begin
      rd_data_q <= mem[rd_phys];
    end
  end

  // Read FSM, frame assembly and underrun handling.
  always_comb begin
    state_d       = state_q;
    rd_ptr_d      = rd_ptr_q;
    rd_bank_d     = rd_bank_q;
    cnt_d         = cnt_q;
    asm_d         = asm_q;
    frame_d       = frame_q;
    frame_valid_d = 1'b0;
    underrun_d    = 1'b0;
    ucnt_d        = ucnt_q;
    rd_en         = 1'b0;
    case (state_q)
      StIdle: begin
        if (sample_tick_i && play_en_i) begin
          if (level_q != '0) begin
            state_d = StFetch;
            cnt_d   = '0;
          end else begin
            frame_d       = '0;
            frame_valid_d = 1'b1;
            underrun_d    = 1'b1;
            if (ucnt_q != 16'hFFFF) begin
              ucnt_d = ucnt_q + 16'd1;
            end
          end
        end
      end
      StFetch: begin
        rd_en    = 1'b1;
        rd_ptr_d = rd_ptr_q + BANK_ADDR_BITS'(1);
        asm_d    = shifted;
        if (cnt_q == CW'(F - 1)) begin
          state_d = StAssemble;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      StAssemble: begin
        frame_d       = shifted;
        frame_valid_d = 1'b1;
        state_d       = StIdle;
        if (release_bank) begin
          rd_bank_d = rd_bank_q + BW'(1);
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Bank bookkeeping: commit advances the write side, release the read side.
  always_comb begin
    wr_bank_d = wr_bank_q;
    level_d   = level_q;
    if (commit) begin
      wr_bank_d = wr_bank_q + BW'(1);
    end
    if (commit && !release_bank) begin
      level_d = level_q + LW'(1);
    end else if (!commit && release_bank) begin
      level_d = level_q - LW'(1);
    end
  end

  // State registers with asynchronous reset; in-flight fetches are discarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= StIdle;
      wr_bank_q     <= '0;
      rd_bank_q     <= '0;
      rd_ptr_q      <= '0;
      cnt_q         <= '0;
      level_q       <= '0;
      asm_q         <= '0;
      frame_q       <= '0;
      frame_valid_q <= 1'b0;
      underrun_q    <= 1'b0;
      ucnt_q        <= '0;
    end else begin
      state_q       <= state_d;
      wr_bank_q     <= wr_bank_d;
      rd_bank_q     <= rd_bank_d;
      rd_ptr_q      <= rd_ptr_d;
      cnt_q         <= cnt_d;
      level_q       <= level_d;
      asm_q         <= asm_d;
      frame_q       <= frame_d;
      frame_valid_q <= frame_valid_d;
      underrun_q    <= underrun_d;
      ucnt_q        <= ucnt_d;
    end
  end

  assign wr_empty_o       = wr_empty;
  assign frame_o          = frame_q;
  assign frame_valid_o    = frame_valid_q;
  assign underrun_o       = underrun_q;
  assign underrun_count_o = ucnt_q;
  assign level_o          = level_q;

endmodule
